// File: rtl/led_arb_pkg.sv
// Shared types, defaults and the round-robin pick helper for the LED display arbiter.
package led_arb_pkg;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_NBITS       = 8;
  localparam int DEF_HOLD_CYCLES = 8;
  localparam int MAX_NREQ        = 8;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req searching ptr, ptr+1, ... modulo n (n <= MAX_NREQ, ptr < n).
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                       input logic [2:0]          ptr,
                                       input int                  n);
    rr_pick_t   r;
    logic [3:0] pos;
    r = '0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= 4'(n)) pos = pos - 4'(n);
      if (k < n && !r.found && req[pos[2:0]]) begin
        r.found = 1'b1;
        r.idx   = pos[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/led_display_arbiter_rr_priority_pick.sv
// Combinational rotate-and-priority-encode of the request vector starting at ptr.
module rr_priority_pick
  import led_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = $clog2(DEF_NREQ)
)(
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            found,
  output logic [PW-1:0]   idx
);

  rr_pick_t pick;
  logic     unused_pick_bits;

  always_comb begin
    pick  = rr_pick(MAX_NREQ'(req), 3'(ptr), NREQ);
    found = pick.found;
    idx   = pick.idx[PW-1:0];
  end

  // Upper index bits are always zero for narrow configurations.
  assign unused_pick_bits = ^pick.idx;

endmodule

// File: rtl/led_display_arbiter.sv
// Round-robin owner of the shared LED display with bounded hold and a one-cycle blank.
// Optional LED_ARB_LOCK_EN adds a per-requester lock input that pauses the hold countdown.
module led_display_arbiter
  import led_arb_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int NBITS       = DEF_NBITS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
)(
  input  logic                       clk_2,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][NBITS-1:0] data,
`ifdef LED_ARB_LOCK_EN
  input  logic [NREQ-1:0]            lock,
`endif
  output logic [NREQ-1:0]            gnt,
  output logic [NBITS-1:0]           led_out,
  output logic [$clog2(NREQ)-1:0]    owner,
  output logic                       busy
);

  localparam int            PW       = $clog2(NREQ);
  localparam int            CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  arb_state_t       state_reg, state_next;
  logic [PW-1:0]    ptr_reg, ptr_next;
  logic [PW-1:0]    owner_reg, owner_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [NBITS-1:0] led_reg, led_next;
  logic             busy_reg, busy_next;

  logic             pick_found;
  logic [PW-1:0]    pick_idx;
  logic [NREQ-1:0]  pick_onehot;
  logic             owner_req, held, hold_exit;

  rr_priority_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_idx == PW'(gi));
    end
  endgenerate

  assign owner_req = req[owner_reg];
`ifdef LED_ARB_LOCK_EN
  assign held = lock[owner_reg] & owner_req;
`else
  assign held = 1'b0;
`endif
  // Dropping req always wins; the counter only ends a hold when not locked.
  assign hold_exit = !owner_req || (cnt_reg == '0 && !held);

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      led_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      led_reg   <= led_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_found) state_next = HOLD;
      HOLD:    if (hold_exit)  state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    gnt_next   = '0;
    led_next   = '0;
    busy_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          owner_next = pick_idx;
          gnt_next   = pick_onehot;
          cnt_next   = CNT_LOAD;
          busy_next  = 1'b1;
        end
      end
      HOLD: begin
        if (hold_exit) begin
          ptr_next = (owner_reg == LAST_IDX) ? '0 : owner_reg + PW'(1);
        end else begin
          gnt_next  = gnt_reg;
          busy_next = 1'b1;
          led_next  = data[owner_reg];
          if (!held && cnt_reg != '0) cnt_next = cnt_reg - CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign gnt     = gnt_reg;
  assign led_out = led_reg;
  assign owner   = owner_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_led_display_arbiter.sv
// Randomized and directed check of led_display_arbiter against a transaction-level model.
module tb_led_display_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int H     = 8;
  localparam int BOUND = (N - 1) * (H + 2) + 2;

  logic               clk_2 = 1'b0;
  logic               reset;
  logic [N-1:0]       req;
  logic [N-1:0][W-1:0] data;
`ifdef LED_ARB_LOCK_EN
  logic [N-1:0]       lock;
`endif
  logic [N-1:0]       gnt;
  logic [W-1:0]       led_out;
  logic [1:0]         owner;
  logic               busy;

  always #5 clk_2 = ~clk_2;

  led_display_arbiter #(.NREQ(N), .NBITS(W), .HOLD_CYCLES(H)) dut (
    .clk_2   (clk_2),
    .reset   (reset),
    .req     (req),
    .data    (data),
`ifdef LED_ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .led_out (led_out),
    .owner   (owner),
    .busy    (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: who owns the display, how many granted cycles remain, blank cycles pending.
  bit         m_active;
  int         m_own, m_ptr, m_left, m_cool;
  logic [W-1:0] m_led;
  int         wait_cnt [N];
  logic [N-1:0] gnt_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_edge();
    bit lk;
    lk = 1'b0;
    if (reset) begin
      m_active = 1'b0; m_own = 0; m_ptr = 0; m_cool = 0; m_left = 0; m_led = '0;
      return;
    end
    if (m_cool > 0) begin
      m_cool--;
      m_led = '0;
    end else if (!m_active) begin
      m_led = '0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (req[c]) begin
          m_active = 1'b1; m_own = c; m_left = H;
          break;
        end
      end
    end else begin
`ifdef LED_ARB_LOCK_EN
      lk = lock[m_own] && req[m_own];
`endif
      if (!req[m_own] || (m_left == 1 && !lk)) begin
        m_active = 1'b0; m_cool = 1; m_led = '0; m_ptr = (m_own + 1) % N;
      end else begin
        m_led = data[m_own];
        if (!lk) m_left--;
      end
    end
  endtask

  task automatic compare();
    check("gnt", 32'(gnt), m_active ? (32'd1 << m_own) : 32'd0);
    check("led_out", 32'(led_out), 32'(m_led));
    check("owner", 32'(owner), 32'(m_own));
    check("busy", 32'(busy), 32'(m_active));
  endtask

  task automatic step();
    for (int i = 0; i < N; i++)
      if (reset || !req[i] || gnt[i]) wait_cnt[i] = 0;
      else wait_cnt[i]++;
    @(posedge clk_2);
    model_edge();
    #1;
    compare();
`ifndef LED_ARB_LOCK_EN
    for (int i = 0; i < N; i++)
      if (gnt[i] && !gnt_prev[i] && wait_cnt[i] > 0)
        check("wait_bound", 32'(wait_cnt[i] <= BOUND), 32'd1);
`endif
    gnt_prev = gnt;
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (gnt == '0 && n < 60) begin
      step();
      n++;
    end
    check(tag, 32'(gnt != '0), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) data[i] = W'($urandom);
  endtask

  initial begin
    int len;
    reset = 1'b1; req = '1; data = '0; gnt_prev = '0;
`ifdef LED_ARB_LOCK_EN
    lock = '0;
`endif
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    m_active = 1'b0; m_own = 0; m_ptr = 0; m_cool = 0; m_left = 0; m_led = '0;

    // Reset held with all requests active.
    repeat (3) begin
      step();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_led", 32'(led_out), 32'd0);
    end
    reset = 1'b0;
    wait_grant("first_wait");
    check("first_gnt", 32'(gnt), 32'd1);

    // Single requester, full hold, gap, re-grant.
    do_reset();
    req = 4'b0100; data = '0; data[2] = 8'hA5;
    wait_grant("single_wait");
    len = 0;
    while (gnt == 4'b0100 && len < 50) begin
      len++;
      if (len >= 2) check("single_led", 32'(led_out), 32'hA5);
      step();
    end
    check("single_len", 32'(len), 32'(H));
    check("gap_led", 32'(led_out), 32'd0);
    step();
    check("idle_gnt", 32'(gnt), 32'd0);
    step();
    check("regrant", 32'(gnt), 32'b0100);

    // Round-robin rotation with everyone requesting.
    do_reset();
    req = '1;
    for (int g = 0; g < 5; g++) begin
      wait_grant("rr_wait");
      check("rr_owner", 32'(owner), 32'(g % N));
      len = 0;
      while (gnt != '0 && len < 50) begin
        len++;
        rand_data();
        step();
      end
      check("rr_len", 32'(len), 32'(H));
    end

    // Early release on the third hold cycle.
    do_reset();
    req = 4'b0010;
    wait_grant("early_wait");
    step();
    step();
    req = 4'b0101;
    step();
    check("early_gnt", 32'(gnt), 32'd0);
    check("early_led", 32'(led_out), 32'd0);
    wait_grant("early_wait2");
    check("early_next", 32'(owner), 32'd2);

`ifdef LED_ARB_LOCK_EN
    // Lock extends the hold; countdown resumes from the held value.
    do_reset();
    req = 4'b0001; lock = 4'b0001;
    wait_grant("lock_wait");
    repeat (20) begin
      step();
      check("lock_hold", 32'(gnt), 32'd1);
    end
    lock = '0;
    len = 0;
    step();
    while (gnt == 4'b0001 && len < 50) begin
      len++;
      step();
    end
    check("lock_resume", 32'(len), 32'(H - 1));
    wait_grant("lock_wait2");
    lock = 4'b0001;
    repeat (3) step();
    req = '0;
    step();
    check("lock_release", 32'(gnt), 32'd0);
    lock = '0;
`endif

    // Randomized traffic with occasional resets.
    do_reset();
    req = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      rand_data();
`ifdef LED_ARB_LOCK_EN
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) lock[i] = ~lock[i];
`endif
      reset = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
